// File: rtl/mem_write_buffer.sv
`default_nettype none
// ============================================================================
//  Module   : mem_write_buffer
//  Purpose  : Posted-write buffer between a cache's memory-side port and main
//             memory. Writebacks are absorbed into a DEPTH-entry FIFO and
//             complete in one cycle; they drain to memory in order. Refills
//             are sent downstream only once every older write has drained,
//             which keeps read-after-write ordering intact.
//  Ports    : clk_i/rst_i          clock, synchronous active-high reset
//             up_*                 cache-side request/response
//             dn_*                 memory-side request/response
//             wb_count_o/empty_o   FIFO occupancy status
//  Options  : `define WB_FWD_EN enables store-to-load forwarding of reads
//             that hit a buffered write (ST_FWD state and comparators).
//  Revision : 1.0 - initial release
// ============================================================================
module mem_write_buffer #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 16,
  parameter int DEPTH      = 4
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    up_valid_i,
  output logic                    up_ready_o,
  input  logic                    up_we_i,
  input  logic [ADDR_WIDTH-1:0]   up_adr_i,
  input  logic [DATA_WIDTH-1:0]   up_wdata_i,
  output logic [DATA_WIDTH-1:0]   up_rdata_o,
  output logic                    dn_valid_o,
  input  logic                    dn_ready_i,
  output logic                    dn_we_o,
  output logic [ADDR_WIDTH-1:0]   dn_adr_o,
  output logic [DATA_WIDTH-1:0]   dn_wdata_o,
  input  logic [DATA_WIDTH-1:0]   dn_rdata_i,
  output logic [$clog2(DEPTH):0]  wb_count_o,
  output logic                    wb_empty_o
);

  localparam int c_ptr_w = $clog2(DEPTH);
  localparam int c_cnt_w = c_ptr_w + 1;
  localparam logic [c_cnt_w-1:0] c_depth = c_cnt_w'(DEPTH);

`ifdef WB_FWD_EN
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WR   = 2'd1,
    ST_RD   = 2'd2,
    ST_FWD  = 2'd3
  } state_t;
`else
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WR   = 2'd1,
    ST_RD   = 2'd2
  } state_t;
`endif

  state_t                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   adr_mem_q [DEPTH];
  logic [DATA_WIDTH-1:0]   dat_mem_q [DEPTH];
  logic [c_ptr_w-1:0]      rd_ptr_q, wr_ptr_q;
  logic [c_cnt_w-1:0]      count_q, count_d;
  logic [ADDR_WIDTH-1:0]   rd_adr_q, rd_adr_d;

  logic                    w_push;
  logic                    w_pop;
  logic                    w_in_wr;
  logic                    w_in_rd;
  logic                    w_rd_done;

  // A full buffer never accepts, even if the head drains this same cycle.
  assign w_push    = up_valid_i & up_we_i & (count_q < c_depth);
  assign w_in_wr   = (state_q == ST_WR);
  assign w_in_rd   = (state_q == ST_RD);
  assign w_pop     = w_in_wr & dn_ready_i & (count_q != '0);
  assign w_rd_done = w_in_rd & dn_ready_i;

`ifdef WB_FWD_EN
  logic                    w_fwd_hit;
  logic [DATA_WIDTH-1:0]   w_fwd_data;
  logic [DATA_WIDTH-1:0]   fwd_data_q, fwd_data_d;
  logic                    w_fwd_done;

  assign w_fwd_done = (state_q == ST_FWD);

  // Scan oldest to newest so the last match (the newest write) wins.
  always_comb begin
    logic [c_ptr_w-1:0] idx;
    w_fwd_hit  = 1'b0;
    w_fwd_data = '0;
    idx        = '0;
    for (int k = 0; k < DEPTH; k++) begin
      idx = rd_ptr_q + c_ptr_w'(k);
      if ((c_cnt_w'(k) < count_q) && (adr_mem_q[idx] == up_adr_i)) begin
        w_fwd_hit  = 1'b1;
        w_fwd_data = dat_mem_q[idx];
      end
    end
  end
`endif

  // FIFO storage carries no reset: validity is tracked by the pointers/count.
  always_ff @(posedge clk_i) begin
    if (w_push) begin
      adr_mem_q[wr_ptr_q] <= up_adr_i;
      dat_mem_q[wr_ptr_q] <= up_wdata_i;
    end
  end

  always_comb begin
    count_d = count_q;
    case ({w_push, w_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= ST_IDLE;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      rd_adr_q   <= '0;
`ifdef WB_FWD_EN
      fwd_data_q <= '0;
`endif
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      rd_adr_q   <= rd_adr_d;
`ifdef WB_FWD_EN
      fwd_data_q <= fwd_data_d;
`endif
      // DEPTH is a power of two, so pointers wrap naturally.
      if (w_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (w_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  always_comb begin
    state_d    = state_q;
    rd_adr_d   = rd_adr_q;
`ifdef WB_FWD_EN
    fwd_data_d = fwd_data_q;
`endif
    case (state_q)
      ST_IDLE: begin
`ifdef WB_FWD_EN
        if (up_valid_i && !up_we_i && w_fwd_hit) begin
          state_d    = ST_FWD;
          fwd_data_d = w_fwd_data;
        end else
`endif
        if (count_q != '0) begin
          state_d = ST_WR;
        end else if (up_valid_i && !up_we_i) begin
          rd_adr_d = up_adr_i;
          state_d  = ST_RD;
        end
      end
      // Returning to idle after each drain leaves a bubble where a pending
      // read can be reconsidered against the updated count.
      ST_WR:   if (dn_ready_i) state_d = ST_IDLE;
      ST_RD:   if (dn_ready_i) state_d = ST_IDLE;
`ifdef WB_FWD_EN
      ST_FWD:  state_d = ST_IDLE;
`endif
      default: state_d = ST_IDLE;
    endcase
  end

`ifdef WB_FWD_EN
  assign up_ready_o = w_push | w_rd_done | w_fwd_done;
  assign up_rdata_o = w_rd_done  ? dn_rdata_i :
                      w_fwd_done ? fwd_data_q : '0;
`else
  assign up_ready_o = w_push | w_rd_done;
  assign up_rdata_o = w_rd_done ? dn_rdata_i : '0;
`endif

  assign dn_valid_o = w_in_wr | w_in_rd;
  assign dn_we_o    = w_in_wr;
  assign dn_adr_o   = w_in_wr ? adr_mem_q[rd_ptr_q] :
                      w_in_rd ? rd_adr_q : '0;
  assign dn_wdata_o = w_in_wr ? dat_mem_q[rd_ptr_q] : '0;
  assign wb_count_o = count_q;
  assign wb_empty_o = (count_q == '0);

endmodule
`default_nettype wire
